io_bus_ctrl: RTL and testbench

Memory-mapped I/O controller between the single-cycle ARM core's data port and the data memory. It decodes `DataAdr` into the data-memory window or a block of I/O registers, then gates memory writes and muxes `ReadData` back to the core. The registers drive LEDs, sample switches through a synchronizer, and run a compare timer with sticky status flags and an interrupt line. Read data is combinational to match the core's single-cycle load timing; every register update is synchronous.

---
 rtl/io_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O controller between the core data port and data memory.
// Decodes the data-memory window and a 0x20-byte I/O register block (LED, SW, CTRL,
// CMP, CNT, STATUS), runs a compare timer and raises a level interrupt.
// Optional feature macro: IO_CTRL_SW_EDGE_EN (switch-change detection, STATUS[1], CTRL[3]).
module io_bus_ctrl #(
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [31:0] IO_BASE    = 32'h0000_0800,
  parameter int unsigned SW_WIDTH   = 8,
  parameter int unsigned LED_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic [31:0]          DataAdr,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 DmemWE,
  input  logic [31:0]          DmemRD,
  input  logic [SW_WIDTH-1:0]  SwIn,
  output logic [LED_WIDTH-1:0] LedOut,
  output logic                 Irq
);

  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_CNT    = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

`ifdef IO_CTRL_SW_EDGE_EN
  localparam logic [3:0] CTRL_MASK   = 4'b1111;
  localparam logic [2:0] STATUS_MASK = 3'b111;
`else
  localparam logic [3:0] CTRL_MASK   = 4'b0111;
  localparam logic [2:0] STATUS_MASK = 3'b101;
`endif

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]  sw_sync_q, sw_sync_d;
  logic [3:0]           ctrl_q, ctrl_d;
  logic [31:0]          cmp_q, cmp_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [2:0]           status_q, status_d;
`ifdef IO_CTRL_SW_EDGE_EN
  logic [SW_WIDTH-1:0]  sw_hist_q, sw_hist_d;
`endif

  logic       dmem_hit;
  logic       io_hit;
  logic       io_wr;
  logic       bus_err;
  logic       match;
  logic       sw_chg;
  logic [2:0] off;
  logic [2:0] w1c;

  // Address decode and write qualification
  always_comb begin
    dmem_hit = (DataAdr < DMEM_BYTES);
    io_hit   = (DataAdr[31:5] == IO_BASE[31:5]);
    off      = DataAdr[4:2];
    io_wr    = MemWrite & io_hit & ~dmem_hit;
    bus_err  = MemWrite & ~dmem_hit & ~io_hit;
    DmemWE   = MemWrite & dmem_hit & ~reset;
  end

  // Load data mux; unmapped offsets and misses return zero
  always_comb begin
    ReadData = '0;
    if (dmem_hit) begin
      ReadData = DmemRD;
    end else if (io_hit) begin
      case (off)
        OFF_LED:    ReadData = 32'(led_q);
        OFF_SW:     ReadData = 32'(sw_sync_q);
        OFF_CTRL:   ReadData = 32'(ctrl_q);
        OFF_CMP:    ReadData = cmp_q;
        OFF_CNT:    ReadData = cnt_q;
        OFF_STATUS: ReadData = 32'(status_q);
        default:    ReadData = '0;
      endcase
    end
  end

  // Next-state for registers, timer, synchronizer and sticky status
  always_comb begin
    led_d     = led_q;
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    cnt_d     = cnt_q;
    w1c       = '0;
    sw_meta_d = SwIn;
    sw_sync_d = sw_meta_q;
`ifdef IO_CTRL_SW_EDGE_EN
    sw_hist_d = sw_sync_q;
    sw_chg    = (sw_sync_q != sw_hist_q);
`else
    sw_chg    = 1'b0;
`endif

    // Compare always sees the pre-write count
    match = ctrl_q[0] && (cnt_q == cmp_q);
    if (ctrl_q[0]) begin
      cnt_d = (match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
    end

    if (io_wr) begin
      case (off)
        OFF_LED:    led_d  = WriteData[LED_WIDTH-1:0];
        OFF_CTRL:   ctrl_d = WriteData[3:0] & CTRL_MASK;
        OFF_CMP:    cmp_d  = WriteData;
        OFF_CNT:    cnt_d  = WriteData;
        OFF_STATUS: w1c    = WriteData[2:0] & STATUS_MASK;
        default:    ;
      endcase
    end

    // Set wins over a same-cycle clear
    status_d = ((status_q & ~w1c) | {bus_err, sw_chg, match}) & STATUS_MASK;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      ctrl_q    <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      cnt_q     <= '0;
      status_q  <= '0;
`ifdef IO_CTRL_SW_EDGE_EN
      sw_hist_q <= '0;
`endif
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
`ifdef IO_CTRL_SW_EDGE_EN
      sw_hist_q <= sw_hist_d;
`endif
    end
  end

  // Outputs derived from register state only
  always_comb begin
    LedOut = led_q;
`ifdef IO_CTRL_SW_EDGE_EN
    Irq = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
`else
    Irq = status_q[0] & ctrl_q[2];
`endif
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: stimulus pushes expected values, a negedge monitor
// pops and compares them against the DUT outputs of the current cycle.
module tb_io_bus_ctrl;

  localparam int K_RD  = 0;
  localparam int K_WE  = 1;
  localparam int K_LED = 2;
  localparam int K_IRQ = 3;

`ifdef IO_CTRL_SW_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        DmemWE;
  logic [31:0] DmemRD;
  logic [7:0]  SwIn;
  logic [7:0]  LedOut;
  logic        Irq;

  logic [31:0] mem [64];

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  io_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .DmemWE    (DmemWE),
    .DmemRD    (DmemRD),
    .SwIn      (SwIn),
    .LedOut    (LedOut),
    .Irq       (Irq)
  );

  // Data memory model
  assign DmemRD = mem[DataAdr[7:2]];
  always @(posedge clk) if (DmemWE) mem[DataAdr[7:2]] <= WriteData;

  // Monitor: compare every queued expectation at the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RD:    mon_act = ReadData;
        K_WE:    mon_act = 32'(DmemWE);
        K_LED:   mon_act = 32'(LedOut);
        default: mon_act = 32'(Irq);
      endcase
      n_vec++;
      if (mon_act !== mon_e.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic expect_val(input int kind, input string nm, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input string nm);
    MemWrite = 1'b0;
    DataAdr  = a;
    expect_val(K_RD, nm, exp);
    cyc();
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic we, input string nm);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    expect_val(K_WE, nm, 32'(we));
    cyc();
    MemWrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; SwIn = '0;
    repeat (2) cyc();
    reset = 1'b0;

    // Reset values
    ld(32'h800, 32'h0, "rst_led");
    ld(32'h804, 32'h0, "rst_sw");
    ld(32'h808, 32'h0, "rst_ctrl");
    ld(32'h80C, 32'hFFFF_FFFF, "rst_cmp");
    ld(32'h810, 32'h0, "rst_cnt");
    expect_val(K_LED, "rst_ledout", 32'h0);
    expect_val(K_IRQ, "rst_irq", 32'h0);
    ld(32'h814, 32'h0, "rst_status");

    // LED store, same-cycle load returns old value
    MemWrite = 1'b1; DataAdr = 32'h800; WriteData = 32'h5A;
    expect_val(K_WE, "led_st_we", 32'h0);
    expect_val(K_RD, "led_st_old", 32'h0);
    cyc();
    MemWrite = 1'b0;
    expect_val(K_LED, "ledout", 32'h5A);
    ld(32'h800, 32'h5A, "led_rd");
    st(32'h64, 32'h7, 1'b1, "dmem_we");
    ld(32'h64, 32'h7, "dmem_rd");

    // Timer with auto-reload and match interrupt
    st(32'h80C, 32'h3, 1'b0, "cmp_we");
    st(32'h808, 32'h7, 1'b0, "ctrl_we");
    ld(32'h810, 32'd0, "cnt0");
    ld(32'h810, 32'd1, "cnt1");
    ld(32'h810, 32'd2, "cnt2");
    expect_val(K_IRQ, "irq_pre", 32'h0);
    ld(32'h810, 32'd3, "cnt3");
    expect_val(K_IRQ, "irq_match", 32'h1);
    ld(32'h810, 32'd0, "cnt_reload");
    ld(32'h814, 32'h1, "status_match");
    st(32'h814, 32'h1, 1'b0, "w1c_we");
    expect_val(K_IRQ, "irq_clr", 32'h0);
    st(32'h808, 32'h0, 1'b0, "ctrl_off");
    st(32'h814, 32'h1, 1'b0, "w1c2_we");
    ld(32'h814, 32'h0, "status_clr");
    ld(32'h810, 32'd0, "cnt_reload2");

    // Free run, CNT write override, 32-bit wrap, hold when disabled
    st(32'h808, 32'h1, 1'b0, "ctrl_run");
    st(32'h810, 32'd10, 1'b0, "cnt_we");
    ld(32'h810, 32'd10, "cnt10");
    ld(32'h810, 32'd11, "cnt11");
    ld(32'h814, 32'h0, "status_nomatch");
    st(32'h810, 32'hFFFF_FFFE, 1'b0, "cnt_we2");
    ld(32'h810, 32'hFFFF_FFFE, "cnt_fffe");
    ld(32'h810, 32'hFFFF_FFFF, "cnt_ffff");
    ld(32'h810, 32'h0, "cnt_wrap");
    st(32'h808, 32'h0, 1'b0, "ctrl_stop");
    ld(32'h810, 32'd2, "cnt_hold_a");
    ld(32'h810, 32'd2, "cnt_hold_b");
    ld(32'h814, 32'h0, "status_wrap");

    // Window boundaries and bus error
    st(32'h0, 32'hDEAD_BEEF, 1'b1, "dmem0_we");
    st(32'hFC, 32'h1234_5678, 1'b1, "dmem_top_we");
    ld(32'hFC, 32'h1234_5678, "dmem_top_rd");
    st(32'h400, 32'h5, 1'b0, "miss_we");
    ld(32'h400, 32'h0, "miss_rd");
    expect_val(K_IRQ, "irq_buserr", 32'h0);
    ld(32'h814, 32'h4, "status_buserr");
    st(32'h814, 32'h4, 1'b0, "w1c_be_we");
    ld(32'h814, 32'h0, "status_be_clr");
    st(32'h100, 32'h1, 1'b0, "edge_miss_we");
    ld(32'h814, 32'h4, "status_be2");
    ld(32'h818, 32'h0, "unmapped_rd");
    st(32'h818, 32'hFF, 1'b0, "unmapped_we");
    ld(32'h0, 32'hDEAD_BEEF, "dmem0_rd");
    ld(32'h814, 32'h4, "status_unmapped");

    // Switch synchronizer and change detection
    st(32'h814, 32'h7, 1'b0, "w1c_all");
    st(32'h808, 32'h8, 1'b0, "ctrl_swie");
    ld(32'h808, EDGE ? 32'h8 : 32'h0, "ctrl_swie_rd");
    SwIn = 8'h81;
    ld(32'h804, 32'h0, "sw_e0");
    ld(32'h804, 32'h0, "sw_e1");
    expect_val(K_IRQ, "irq_sw_pre", 32'h0);
    ld(32'h804, 32'h81, "sw_e2");
    expect_val(K_IRQ, "irq_sw", EDGE ? 32'h1 : 32'h0);
    ld(32'h814, EDGE ? 32'h2 : 32'h0, "status_sw");
    st(32'h804, 32'hFF, 1'b0, "sw_ro_we");
    ld(32'h804, 32'h81, "sw_ro_rd");
    st(32'h814, 32'h2, 1'b0, "w1c_sw");
    expect_val(K_IRQ, "irq_sw_clr", 32'h0);
    ld(32'h814, 32'h0, "status_sw_clr");

    // Reset mid-count discards state and blocks the memory write
    st(32'h808, 32'h1, 1'b0, "ctrl_run2");
    st(32'h810, 32'd5, 1'b0, "cnt_we3");
    reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'h10; WriteData = 32'h9;
    expect_val(K_WE, "rst_we", 32'h0);
    cyc();
    reset = 1'b0; MemWrite = 1'b0;
    expect_val(K_LED, "rst2_ledout", 32'h0);
    ld(32'h810, 32'h0, "rst2_cnt");
    ld(32'h80C, 32'hFFFF_FFFF, "rst2_cmp");
    ld(32'h808, 32'h0, "rst2_ctrl");
    ld(32'h10, 32'h0, "rst2_dmem");

    cyc();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
